// File: rtl/calc_pkg.sv
// ============================================================================
//  Module   : calc_pkg
//  Brief    : Shared key codes, lane codes and entry-FSM states for the
//             calculator game answer-entry path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

   localparam logic [3:0] KEY_A = 4'd10;
   localparam logic [3:0] KEY_B = 4'd11;
   localparam logic [3:0] KEY_C = 4'd12;
   localparam logic [3:0] KEY_D = 4'd13;
   localparam logic [3:0] KEY_E = 4'd14;
   localparam logic [3:0] KEY_F = 4'd15;

   localparam logic [1:0] LANE_NONE = 2'b00;
   localparam logic [1:0] LANE_1    = 2'b01;
   localparam logic [1:0] LANE_2    = 2'b10;
   localparam logic [1:0] LANE_3    = 2'b11;

   typedef enum logic [0:0] {
      ST_ENTRY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Submit keys A/B/C map onto lanes 1/2/3.
   function automatic logic [1:0] key_lane(input logic [3:0] code);
      logic [3:0] t;
      t = code - 4'd9;
      return t[1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
//  Module   : keypad_scan
//  Brief    : 4x4 matrix keypad scanner with per-key debounce; emits one
//             key_valid pulse per accepted press, lowest key code wins.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scan #(
   parameter int SCAN_DIV = 1024,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] kp_row,
   output logic [3:0] kp_col,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_deb_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE - 1);

   logic [c_div_w-1:0] r_div;
   logic [1:0]         r_col;
   logic               w_sample;
   logic [15:0]        w_stable;
   logic [3:0]         w_low;
   logic               r_locked;
   logic               r_valid;
   logic [3:0]         r_code;

   // Rows are sampled on the last divider cycle, just before the column moves.
   assign w_sample = (r_div == c_div_last);
   assign kp_col   = ~(4'b0001 << r_col);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_col <= 2'd0;
      end else if (w_sample) begin
         r_div <= '0;
         r_col <= r_col + 2'd1;
      end else begin
         r_div <= r_div + c_div_w'(1);
      end
   end

   for (genvar k = 0; k < 16; k++) begin : g_key
      localparam int         c_row = k / 4;
      localparam logic [1:0] c_col = 2'(k % 4);

      logic [c_deb_w-1:0] r_cnt;
      logic               r_stb;
      logic               w_raw;

      assign w_raw       = ~kp_row[c_row];
      assign w_stable[k] = r_stb;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
         end else if (w_sample && (r_col == c_col)) begin
            if (w_raw == r_stb) begin
               r_cnt <= '0;
            end else if (r_cnt == c_deb_last) begin
               r_cnt <= '0;
               r_stb <= w_raw;
            end else begin
               r_cnt <= r_cnt + c_deb_w'(1);
            end
         end
      end
   end

   always_comb begin
      w_low = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_stable[i]) w_low = 4'(i);
      end
   end

   // Lock after a press; re-arm only once every key reads released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_locked <= 1'b0;
         r_valid  <= 1'b0;
         r_code   <= 4'd0;
      end else begin
         r_valid <= 1'b0;
         if (!r_locked && (|w_stable)) begin
            r_locked <= 1'b1;
            r_valid  <= 1'b1;
            r_code   <= w_low;
         end else if (r_locked && !(|w_stable)) begin
            r_locked <= 1'b0;
         end
      end
   end

   assign key_valid = r_valid;
   assign key_code  = r_code;

endmodule

`default_nettype wire

// File: rtl/answer_entry.sv
// ============================================================================
//  Module   : answer_entry
//  Brief    : Keypad answer entry; accumulates up to three decimal digits and
//             holds the submitted answer/lane for the slow game clock.
//             Optional signed entry enabled by defining NEG_ENTRY_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module answer_entry #(
   parameter int SCAN_DIV    = 1024,
   parameter int DEBOUNCE    = 4,
   parameter int HOLD_CYCLES = 131072
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] kp_row,
   output logic [3:0] kp_col,
   output logic [1:0] in_line,
   output logic [7:0] in_ans,
   output logic [7:0] disp_val,
   output logic [1:0] digit_cnt
);
   import calc_pkg::*;

   localparam logic [17:0] c_hold_last = 18'(HOLD_CYCLES - 1);

   logic        w_key_valid;
   logic [3:0]  w_key_code;
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_val, w_val_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic        r_neg, w_neg_nxt;
   logic [17:0] r_hold, w_hold_nxt;
   logic [1:0]  r_line, w_line_nxt;
   logic [7:0]  r_ans, w_ans_nxt;
   logic [7:0]  r_disp, w_disp_nxt;
   logic [11:0] w_prod;
   logic [11:0] w_limit;

   keypad_scan #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .kp_row    (kp_row),
      .kp_col    (kp_col),
      .key_valid (w_key_valid),
      .key_code  (w_key_code)
   );

   assign w_prod = 12'(r_val) * 12'd10 + 12'(w_key_code);

`ifdef NEG_ENTRY_EN
   assign w_limit = r_neg ? 12'd128 : 12'd127;
`else
   assign w_limit = 12'd255;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ENTRY;
         r_val   <= 8'd0;
         r_cnt   <= 2'd0;
         r_neg   <= 1'b0;
         r_hold  <= 18'd0;
         r_line  <= LANE_NONE;
         r_ans   <= 8'd0;
         r_disp  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_val   <= w_val_nxt;
         r_cnt   <= w_cnt_nxt;
         r_neg   <= w_neg_nxt;
         r_hold  <= w_hold_nxt;
         r_line  <= w_line_nxt;
         r_ans   <= w_ans_nxt;
         r_disp  <= w_disp_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_val_nxt   = r_val;
      w_cnt_nxt   = r_cnt;
      w_neg_nxt   = r_neg;
      w_hold_nxt  = r_hold;
      w_line_nxt  = r_line;
      w_ans_nxt   = r_ans;
      unique case (r_state)
         ST_ENTRY: begin
            if (w_key_valid) begin
               if (w_key_code <= 4'd9) begin
                  if ((r_cnt != 2'd3) && (w_prod <= w_limit)) begin
                     w_val_nxt = w_prod[7:0];
                     w_cnt_nxt = r_cnt + 2'd1;
                  end
               end else if (w_key_code == KEY_D) begin
                  w_val_nxt = 8'd0;
                  w_cnt_nxt = 2'd0;
                  w_neg_nxt = 1'b0;
               end else if (w_key_code == KEY_E) begin
                  // Backspacing to an empty entry also drops the sign.
                  if (r_cnt != 2'd0) begin
                     w_val_nxt = r_val / 8'd10;
                     w_cnt_nxt = r_cnt - 2'd1;
                     if (r_cnt == 2'd1) w_neg_nxt = 1'b0;
                  end
`ifdef NEG_ENTRY_EN
               end else if (w_key_code == KEY_F) begin
                  // Refuse to flip -128 to +128, which is unrepresentable.
                  if ((r_cnt != 2'd0) && (!r_neg || (r_val <= 8'd127))) begin
                     w_neg_nxt = ~r_neg;
                  end
`endif
               end else if ((w_key_code >= KEY_A) && (w_key_code <= KEY_C)) begin
                  if (r_cnt != 2'd0) begin
                     w_line_nxt  = key_lane(w_key_code);
                     w_ans_nxt   = r_neg ? (~r_val + 8'd1) : r_val;
                     w_val_nxt   = 8'd0;
                     w_cnt_nxt   = 2'd0;
                     w_neg_nxt   = 1'b0;
                     w_hold_nxt  = 18'd0;
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (r_hold != '1) w_hold_nxt = r_hold + 18'd1;
            if (r_hold == c_hold_last) begin
               w_line_nxt  = LANE_NONE;
               w_ans_nxt   = 8'd0;
               w_state_nxt = ST_ENTRY;
            end
         end
         default: w_state_nxt = ST_ENTRY;
      endcase
      w_disp_nxt = w_neg_nxt ? (~w_val_nxt + 8'd1) : w_val_nxt;
   end

   assign in_line   = r_line;
   assign in_ans    = r_ans;
   assign disp_val  = r_disp;
   assign digit_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_answer_entry.sv
// ============================================================================
//  Module   : tb_answer_entry
//  Brief    : Self-checking bench for answer_entry with a keypad model and a
//             behavioural entry model; build with NEG_ENTRY_EN for signed mode.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_answer_entry;

   localparam int SCAN_DIV    = 4;
   localparam int DEBOUNCE    = 2;
   localparam int HOLD_CYCLES = 16;
`ifdef NEG_ENTRY_EN
   localparam bit NEG = 1'b1;
`else
   localparam bit NEG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] kp_row;
   logic [3:0] kp_col;
   logic [1:0] in_line;
   logic [7:0] in_ans;
   logic [7:0] disp_val;
   logic [1:0] digit_cnt;

   logic [15:0] pressed = 16'd0;
   int          n_cmp = 0;
   int          n_err = 0;

   int         m_val = 0;
   int         m_cnt = 0;
   bit         m_neg = 1'b0;
   logic [9:0] exp_q[$];

   bit         mon_en    = 1'b0;
   bit         abort_run = 1'b0;
   logic [1:0] prev_line = 2'b00;
   logic [9:0] held;
   logic [9:0] exp_sub;
   bit         changed;
   int         run = 0;

   answer_entry #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE    (DEBOUNCE),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .kp_row    (kp_row),
      .kp_col    (kp_col),
      .in_line   (in_line),
      .in_ans    (in_ans),
      .disp_val  (disp_val),
      .digit_cnt (digit_cnt)
   );

   always #5 clk = ~clk;

   // Matrix keypad: a held key pulls its row low while its column is driven.
   always_comb begin
      kp_row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
         end
      end
   end

   function automatic void model_key(input int k);
      int lim;
      lim = NEG ? (m_neg ? 128 : 127) : 255;
      if (k <= 9) begin
         if (m_cnt < 3 && m_val * 10 + k <= lim) begin
            m_val = m_val * 10 + k;
            m_cnt = m_cnt + 1;
         end
      end else if (k >= 10 && k <= 12) begin
         if (m_cnt > 0) begin
            exp_q.push_back({2'(k - 9), 8'(m_neg ? 256 - m_val : m_val)});
            m_val = 0;
            m_cnt = 0;
            m_neg = 1'b0;
         end
      end else if (k == 13) begin
         m_val = 0;
         m_cnt = 0;
         m_neg = 1'b0;
      end else if (k == 14) begin
         if (m_cnt > 0) begin
            m_val = m_val / 10;
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_neg = 1'b0;
         end
      end else if (NEG && m_cnt > 0 && (!m_neg || m_val <= 127)) begin
         m_neg = !m_neg;
      end
   endfunction

   function automatic logic [7:0] exp_disp();
      return 8'(m_neg ? 256 - m_val : m_val);
   endfunction

   task automatic press(input int k);
      @(negedge clk);
      model_key(k);
      pressed[k] = 1'b1;
      repeat (48) @(negedge clk);
      pressed[k] = 1'b0;
      repeat (48) @(negedge clk);
   endtask

   // Submission monitor: value, exact hold length and constancy of each run.
   always @(negedge clk) begin
      if (mon_en) begin
         if (in_line != 2'b00) begin
            if (prev_line == 2'b00) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL submit_unexpected: got lane %0d ans %0d, required no submission", in_line, in_ans);
               end else begin
                  exp_sub = exp_q.pop_front();
                  if ({in_line, in_ans} !== exp_sub) begin
                     n_err++;
                     $display("FAIL submit_value: got lane %0d ans 0x%02h, required lane %0d ans 0x%02h",
                              in_line, in_ans, exp_sub[9:8], exp_sub[7:0]);
                  end
               end
               held    = {in_line, in_ans};
               changed = 1'b0;
               run     = 0;
            end else if ({in_line, in_ans} != held) begin
               changed = 1'b1;
            end
            run++;
         end else if (prev_line != 2'b00) begin
            if (!abort_run) begin
               n_cmp++;
               if (run != HOLD_CYCLES || changed) begin
                  n_err++;
                  $display("FAIL hold_len: got %0d cycles (changed=%0d), required %0d constant cycles",
                           run, changed, HOLD_CYCLES);
               end
               n_cmp++;
               if (in_ans !== 8'd0) begin
                  n_err++;
                  $display("FAIL ans_clear: got 0x%02h, required 0x00", in_ans);
               end
            end
            abort_run = 1'b0;
         end
         prev_line = in_line;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (kp_col !== 4'b1110 || in_line !== 2'b00 || in_ans !== 8'd0 ||
          disp_val !== 8'd0 || digit_cnt !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got col %b line %b ans %0d disp %0d cnt %0d, required 1110 00 0 0 0",
                  kp_col, in_line, in_ans, disp_val, digit_cnt);
      end
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (kp_col !== 4'b1110) begin
         n_err++;
         $display("FAIL col_hold: got %b, required 1110", kp_col);
      end
      @(negedge clk);
      n_cmp++;
      if (kp_col !== 4'b1101) begin
         n_err++;
         $display("FAIL col_step: got %b, required 1101", kp_col);
      end
   endtask

   task automatic test_submit();
      press(1);
      press(2);
      n_cmp++;
      if (disp_val !== exp_disp() || digit_cnt !== 2'(m_cnt)) begin
         n_err++;
         $display("FAIL typed_12: got disp %0d cnt %0d, required %0d %0d", disp_val, digit_cnt, exp_disp(), m_cnt);
      end
      press(11);
      n_cmp++;
      if (disp_val !== 8'd0 || digit_cnt !== 2'd0 || in_line !== 2'b00) begin
         n_err++;
         $display("FAIL after_submit: got disp %0d cnt %0d line %b, required 0 0 00", disp_val, digit_cnt, in_line);
      end
   endtask

   task automatic test_range();
      int seq[4] = '{2, 5, 6, 5};
      foreach (seq[i]) begin
         press(seq[i]);
         n_cmp++;
         if (disp_val !== exp_disp() || digit_cnt !== 2'(m_cnt)) begin
            n_err++;
            $display("FAIL range_key%0d: got disp %0d cnt %0d, required %0d %0d",
                     seq[i], disp_val, digit_cnt, exp_disp(), m_cnt);
         end
      end
   endtask

   task automatic test_edit();
      int seq[6] = '{13, 4, 7, 14, 13, 12};
      foreach (seq[i]) begin
         press(seq[i]);
         n_cmp++;
         if (disp_val !== exp_disp() || digit_cnt !== 2'(m_cnt) || in_line !== 2'b00) begin
            n_err++;
            $display("FAIL edit_key%0d: got disp %0d cnt %0d line %b, required %0d %0d 00",
                     seq[i], disp_val, digit_cnt, in_line, exp_disp(), m_cnt);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      press(9);
      @(negedge clk);
      model_key(10);
      pressed[10] = 1'b1;
      for (int i = 0; i < 100 && in_line == 2'b00; i++) @(negedge clk);
      n_cmp++;
      if (in_line == 2'b00) begin
         n_err++;
         $display("FAIL hold_start: got no submission within 100 cycles, required lane 1");
      end
      pressed[3] = 1'b1;
      repeat (4) @(negedge clk);
      abort_run = 1'b1;
      rst       = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_line !== 2'b00 || in_ans !== 8'd0 || digit_cnt !== 2'd0 || kp_col !== 4'b1110) begin
         n_err++;
         $display("FAIL rst_in_hold: got line %b ans %0d cnt %0d col %b, required 00 0 0 1110",
                  in_line, in_ans, digit_cnt, kp_col);
      end
      pressed = 16'd0;
      rst     = 1'b0;
      m_val   = 0;
      m_cnt   = 0;
      m_neg   = 1'b0;
      repeat (80) @(negedge clk);
      n_cmp++;
      if (digit_cnt !== 2'd0 || disp_val !== 8'd0 || in_line !== 2'b00) begin
         n_err++;
         $display("FAIL hold_key_ignored: got cnt %0d disp %0d line %b, required 0 0 00", digit_cnt, disp_val, in_line);
      end
   endtask

   task automatic test_negative();
      press(5);
      press(15);
      n_cmp++;
      if (disp_val !== exp_disp()) begin
         n_err++;
         $display("FAIL sign_disp: got 0x%02h, required 0x%02h", disp_val, exp_disp());
      end
      press(11);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sign_submit: got %0d pending submissions, required 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      int r;
      int k;
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 19));
         k = (r < 12) ? (r % 10) : int'($urandom_range(10, 15));
         press(k);
         n_cmp++;
         if (disp_val !== exp_disp() || digit_cnt !== 2'(m_cnt)) begin
            n_err++;
            $display("FAIL rand_%0d_key%0d: got disp %0d cnt %0d, required %0d %0d",
                     n, k, disp_val, digit_cnt, exp_disp(), m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_submit();
      test_range();
      test_edit();
      test_reset_in_hold();
      test_negative();
      test_random();
      repeat (40) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL missing_submit: got %0d expected submissions never seen, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
